// File: rtl/lab_hold_scheduler_pkg.sv
// Shared constants, state encoding and id helpers for the LAB hold scheduler.
package lab_hold_scheduler_pkg;

  localparam int NBUF  = 4;
  localparam int BUF_W = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_READY     = 2'd3;

  // Lowest set index of a buffer mask; 0 when the mask is empty.
  function automatic logic [BUF_W-1:0] lowest_id(input logic [NBUF-1:0] mask);
    logic [BUF_W-1:0] id;
    id = 2'd0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (mask[i]) begin
        id = BUF_W'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  function automatic logic [NBUF-1:0] id_onehot(input logic [BUF_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/hold_id_fifo.sv
// Four-entry circular FIFO of buffer ids; the extra pointer bit separates full from empty.
module hold_id_fifo
  import lab_hold_scheduler_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [BUF_W-1:0] din,
  input  logic             pop,
  output logic [BUF_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [BUF_W-1:0] mem_r [NBUF];
  logic [2:0]       wr_ptr_r;
  logic [2:0]       rd_ptr_r;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[2] != rd_ptr_r[2]) && (wr_ptr_r[1:0] == rd_ptr_r[1:0]);
  assign dout  = mem_r[rd_ptr_r[1:0]];

  // Storage and pointer update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= 3'd0;
      rd_ptr_r <= 3'd0;
      for (int i = 0; i < NBUF; i++) begin
        mem_r[i] <= 2'd0;
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[1:0]] <= din;
        wr_ptr_r             <= wr_ptr_r + 3'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + 3'd1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/lab_hold_scheduler.sv
// Queues held TURF buffers in arrival order and walks each one through
// digitize, wait-for-done and ready-until-released.
module lab_hold_scheduler
  import lab_hold_scheduler_pkg::*;
#(
  parameter int DIG_PULSE = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NBUF-1:0]  hold_i,
  input  logic             done_i,
  input  logic [NBUF-1:0]  release_i,
  output logic [NBUF-1:0]  digitize_o,
  output logic [NBUF-1:0]  held_o,
  output logic             ready_o,
  output logic [BUF_W-1:0] cur_buf_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [7:0]       dead_cnt_o
);

  localparam logic [3:0]  PULSE_LAST = 4'(DIG_PULSE - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  logic [NBUF-1:0]  hold_q_r, pending_r, held_r, digitize_r;
  logic [1:0]       state_r;
  logic [BUF_W-1:0] cur_buf_r;
  logic [3:0]       pulse_cnt_r;
  logic [15:0]      wait_cnt_r;
  logic             ready_r, busy_r, timeout_r;
  logic [7:0]       dead_cnt_r;

  logic [NBUF-1:0]  rise_s, new_pend_s, push_mask_s, clr_mask_s;
  logic             lost_s, push_s, pop_s, fifo_empty_s, fifo_full_s, timeout_hit_s;
  logic [BUF_W-1:0] push_id_s, fifo_dout_s, cur_buf_nx_s;
  logic [1:0]       state_nx_s;

  hold_id_fifo u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_s),
    .din   (push_id_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Edge detection, lost-edge detection and selection of the next id to queue
  always_comb begin
    rise_s     = hold_i & ~hold_q_r;
    new_pend_s = rise_s & ~held_r & ~pending_r;
    lost_s     = |(rise_s & (held_r | pending_r));
    push_id_s  = lowest_id(pending_r);
    push_s     = (|pending_r) && !fifo_full_s;
    if (push_s) begin
      push_mask_s = id_onehot(push_id_s);
    end else begin
      push_mask_s = 4'b0000;
    end
  end

  // Next-state logic of the digitize sequencer
  always_comb begin
    state_nx_s    = state_r;
    cur_buf_nx_s  = cur_buf_r;
    pop_s         = 1'b0;
    clr_mask_s    = 4'b0000;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          cur_buf_nx_s = fifo_dout_s;
          state_nx_s   = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          state_nx_s = ST_WAIT_DONE;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_WAIT_DONE: begin
        // done takes precedence over a timeout landing on the same cycle
        if (done_i) begin
          state_nx_s = ST_READY;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_hit_s = 1'b1;
          clr_mask_s    = id_onehot(cur_buf_r);
          state_nx_s    = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_DONE;
        end
      end
      ST_READY: begin
        if (release_i[cur_buf_r]) begin
          clr_mask_s = id_onehot(cur_buf_r);
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_READY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Buffer occupancy bookkeeping and saturating lost-edge counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q_r   <= 4'b0000;
      pending_r  <= 4'b0000;
      held_r     <= 4'b0000;
      dead_cnt_r <= 8'd0;
    end else begin
      hold_q_r  <= hold_i;
      pending_r <= (pending_r & ~push_mask_s) | new_pend_s;
      held_r    <= (held_r | push_mask_s) & ~clr_mask_s;
      if (lost_s && (dead_cnt_r != 8'hFF)) begin
        dead_cnt_r <= dead_cnt_r + 8'd1;
      end else begin
        dead_cnt_r <= dead_cnt_r;
      end
    end
  end

  // Sequencer state, phase counters and registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cur_buf_r   <= 2'd0;
      pulse_cnt_r <= 4'd0;
      wait_cnt_r  <= 16'd0;
      digitize_r  <= 4'b0000;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cur_buf_r   <= cur_buf_nx_s;
      pulse_cnt_r <= ((state_r == ST_START) && (state_nx_s == ST_START)) ?
                     pulse_cnt_r + 4'd1 : 4'd0;
      wait_cnt_r  <= ((state_r == ST_WAIT_DONE) && (state_nx_s == ST_WAIT_DONE)) ?
                     wait_cnt_r + 16'd1 : 16'd0;
      digitize_r  <= (state_nx_s == ST_START) ? id_onehot(cur_buf_nx_s) : 4'b0000;
      busy_r      <= (state_nx_s == ST_START) || (state_nx_s == ST_WAIT_DONE);
      ready_r     <= (state_nx_s == ST_READY);
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end else if (|release_i) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign digitize_o = digitize_r;
  assign held_o     = held_r;
  assign ready_o    = ready_r;
  assign cur_buf_o  = cur_buf_r;
  assign busy_o     = busy_r;
  assign timeout_o  = timeout_r;
  assign dead_cnt_o = dead_cnt_r;

endmodule

// File: doc/lab_hold_scheduler.md
Name: lab_hold_scheduler

Overview:
- Sequences LAB digitization of the four TURF HOLD buffers.
- Captures HOLD edges and queues held buffers in arrival order.
- Issues one-hot digitize requests to the LAB readout one at a time, waits for its done indication, then holds the buffer until the register interface releases it.
- Sits between the HOLD receivers, the LAB readout block (digitize/done) and the PLX register block (status/release), all in the 33 MHz domain.

Parameters:
- NBUF, 4, number of hold buffers (fixed at 4; buffer id is 2 bits).
- DIG_PULSE, 2, digitize_o high time in clk_i cycles (1..15).
- TIMEOUT, 65535, max cycles in WAIT_DONE before abort (16-bit).

Ports:
- clk_i  in  1  33 MHz system clock.
- rst_i  in  1  asynchronous, active-high reset.
- hold_i  in  4  HOLD levels, already synchronous to clk_i; a rising edge marks that buffer held.
- done_i  in  1  LAB readout done (level).
- release_i  in  4  one-cycle pulses from the register block; free the named buffer.
- digitize_o  out  4  one-hot digitize request to the LAB readout.
- held_o  out  4  buffers currently occupied (queued, digitizing or ready).
- ready_o  out  1  digitized data available in cur_buf_o.
- cur_buf_o  out  2  id of the buffer being digitized or ready.
- busy_o  out  1  high in START or WAIT_DONE.
- timeout_o  out  1  sticky; set on WAIT_DONE timeout, cleared by reset or by any release_i.
- dead_cnt_o  out  8  saturating count of HOLD edges lost because the buffer was already held.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0; queue empty; pending mask 0; hold_i edge detector registers loaded to 0. Because of this, a hold_i that is high at reset exit counts as an edge.
- Edge capture: rise[n] = hold_i[n] & ~hold_q[n].
  - If held[n]=0 and pending[n]=0: set pending[n].
  - Otherwise: dead_cnt_o += 1, saturating at 255.
  - Several simultaneous edges are each judged independently. When more than one edge is lost in the same cycle, dead_cnt_o increments by 1 only.
- Queue push: each cycle, the lowest-index pending bit is pushed into the 4-deep id FIFO. Its pending bit clears and its held bit sets, in the same cycle. Simultaneous holds therefore enter in ascending index order, one per cycle. held_o = held bits; a bit is set from push until release.
- The FIFO can never overflow: at most 4 held buffers, and ids are unique.
- FSM states: IDLE, START, WAIT_DONE, READY.
- IDLE:
  - If FIFO is non-empty: pop the head into cur_buf_o, go to START.
  - Push and pop in the same cycle are allowed. An empty FIFO with a simultaneous push does not pop until the next cycle.
- START:
  - digitize_o = 1 << cur_buf_o for exactly DIG_PULSE cycles, registered.
  - Then go to WAIT_DONE.
  - busy_o = 1.
- WAIT_DONE:
  - The counter runs from 0.
  - If done_i = 1: go to READY.
  - If the count reaches TIMEOUT first: set timeout_o, clear held[cur_buf], go to IDLE.
  - If done_i arrives in the same cycle as the timeout, done wins.
- READY:
  - ready_o = 1.
  - When release_i[cur_buf_o] = 1: clear held[cur_buf], ready_o drops the next cycle, go to IDLE.
- release_i in any other case:
  - release_i for a buffer that is only queued is ignored; it does not dequeue.
  - release_i for a non-held buffer is ignored.
- hold_i edge on the buffer being released in the same cycle is counted dead; the held bit is still set that cycle.
- Latency: hold_i rising edge to digitize_o rising edge = 3 cycles when idle (edge register, push, pop to START registered output).
- Reset mid-operation: digitize_o drops immediately (async); queue, state and counters are cleared.

Decomposition:
- Shared package: NBUF; state encoding (IDLE=0, START=1, WAIT_DONE=2, READY=3); buffer-id width (2).
- One sub-module, hold_id_fifo: a 4-entry × 2-bit circular FIFO.
  - Ports: clk_i, rst_i, push, din, pop, dout, empty, full.
  - 3-bit read/write pointers; wrap-around on bit 2.

Test Plan:
- Single hold: hold_i=0001 → digitize_o=0001 for 2 cycles starting 3 cycles after the edge. Then done_i=1 → ready_o=1 with cur_buf_o=0. Then release_i=0001 → held_o=0000 and ready_o=0.
- Simultaneous holds: hold_i 0000→1010 → digitize order is buffer 1, then buffer 3. held_o=1010 until both are released.
- Dead hold: buffer 2 held, hold_i[2] pulsed 300 times → dead_cnt_o=255 (saturates) and digitize_o is issued only once for buffer 2.
- Timeout (TIMEOUT=20): done_i held low → timeout_o=1 at WAIT_DONE cycle 20, held bit cleared, next queued buffer starts. A subsequent release_i clears timeout_o.
- Queue full and wrap: 4 holds queued; release each in turn, then 4 more holds → FIFO order preserved across the pointer wrap, with no lost or duplicated ids.
- Reset during START: assert rst_i while digitize_o=0100 → all outputs 0 asynchronously. After reset exit, a hold_i already high produces a new edge and a new digitize.
